// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the execute-stage integer divider:
//   - DIV_XLEN / DIV_ITER : default operand width and iterations per divide
//   - div_op_e            : RISC-V divide opcode encoding (DIV, DIVU, REM, REMU)
//   - div_state_e         : divider FSM state encoding
//   - div_neg / div_abs   : two's-complement negate and magnitude helpers
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_XLEN = 32;
  localparam int DIV_ITER = DIV_XLEN;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // Bit 0 clear means a signed operation; bit 1 set selects the remainder.
  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

  function automatic logic [DIV_XLEN-1:0] div_neg(input logic [DIV_XLEN-1:0] v);
    return ~v + DIV_XLEN'(1);
  endfunction

  function automatic logic [DIV_XLEN-1:0] div_abs(input logic [DIV_XLEN-1:0] v,
                                                  input logic               is_signed);
    return (is_signed && v[DIV_XLEN-1]) ? div_neg(v) : v;
  endfunction

endpackage

// File: rtl/ex_div_unit.sv
// -----------------------------------------------------------------------------
// ex_div_unit
// Iterative restoring radix-2 divider for the execute stage. One quotient bit
// is produced per clock. The front of the pipeline is stalled from the issue
// cycle until the result is ready; the result is presented with a one-cycle
// done strobe while the pipeline advances.
//
// Ports:
//   sys_clk     in   pipeline clock
//   sys_start   in   asynchronous active-low reset
//   start_i     in   divide request (isdiv from ID/EX)
//   flush_i     in   kill the current or requested divide
//   op_i        in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i  in   rs1 operand
//   divisor_i   in   rs2 operand
//   rd_addr_i   in   destination register
//   stall_o     out  hold PC, IF/ID and ID/EX
//   done_o      out  result valid for exactly one cycle
//   result_o    out  quotient or remainder (held until the next completion)
//   rd_addr_o   out  destination tagged to the result
// -----------------------------------------------------------------------------
module ex_div_unit
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN,
  parameter int ITER = DIV_ITER
) (
  input  logic            sys_clk,
  input  logic            sys_start,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      r_state;
  div_state_e      w_next_state;

  div_op_e         r_op;
  logic [4:0]      r_rd;
  logic            r_qneg;
  logic            r_rneg;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_divisor;

  div_op_e         w_op_in;
  logic            w_in_signed;
  logic            w_accept;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_special;
  logic            w_last;
  logic            w_enter_done;

  logic [XLEN:0]   w_shift_rem;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_next_rem;
  logic [XLEN-1:0] w_next_quo;
  logic [XLEN-1:0] w_mag;
  logic [XLEN-1:0] w_res_normal;
  logic [XLEN-1:0] w_res_special;
  logic [XLEN-1:0] w_result;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_op_in     = div_op_e'(op_i);
  assign w_in_signed = op_is_signed(w_op_in);
  assign w_accept    = (r_state == ST_IDLE) && start_i && !flush_i;
  assign w_div_zero  = (divisor_i == '0);
  assign w_overflow  = w_in_signed && (dividend_i == INT_MIN) && (divisor_i == '1);
  assign w_special   = w_div_zero || w_overflow;
  assign w_last      = (r_cnt == CW'(ITER - 1));

  // The stall is combinational so the divide is held in EX from its issue
  // cycle; it is forced low while reset is asserted so a reset pipeline sees
  // an idle divider immediately.
  assign stall_o = sys_start &&
                   (((r_state == ST_IDLE) && start_i && !flush_i) || (r_state == ST_CALC));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_start) begin
    if (!sys_start) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = w_special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (flush_i)     w_next_state = ST_IDLE;
        else if (w_last) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Completion is entered either straight from IDLE (special cases) or on the
  // final CALC step; a flush overrides both because it forces IDLE.
  assign w_enter_done = (w_next_state == ST_DONE) && (r_state != ST_DONE);

  // ---------------------------------------------------------------------------
  // Restoring step: shift {rem, quo} left, trial-subtract at XLEN+1 bits and
  // keep the difference when it does not borrow.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_shift_rem = {r_rem, r_quo[XLEN-1]};
    w_trial     = w_shift_rem - {1'b0, r_divisor};
    w_next_rem  = w_shift_rem[XLEN-1:0];
    w_next_quo  = {r_quo[XLEN-2:0], 1'b0};
    if (!w_trial[XLEN]) begin
      w_next_rem    = w_trial[XLEN-1:0];
      w_next_quo[0] = 1'b1;
    end
  end

  // Result selection. The normal path uses the values produced by the last
  // step so the result lands on the same edge that enters DONE.
  always_comb begin
    w_mag        = op_is_rem(r_op) ? w_next_rem : w_next_quo;
    w_res_normal = w_mag;
    if (op_is_rem(r_op) ? r_rneg : r_qneg) w_res_normal = div_neg(w_mag);

    w_res_special = '0;
    if (w_div_zero) begin
      w_res_special = op_is_rem(w_op_in) ? dividend_i : '1;
    end else if (w_overflow) begin
      w_res_special = op_is_rem(w_op_in) ? '0 : INT_MIN;
    end

    w_result = (r_state == ST_IDLE) ? w_res_special : w_res_normal;
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_start) begin
    if (!sys_start) begin
      r_op      <= OP_DIV;
      r_rd      <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
      done_o    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= w_op_in;
        r_rd      <= rd_addr_i;
        r_qneg    <= w_in_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
        r_rneg    <= w_in_signed && dividend_i[XLEN-1];
        r_cnt     <= '0;
        r_rem     <= '0;
        r_quo     <= div_abs(dividend_i, w_in_signed);
        r_divisor <= div_abs(divisor_i, w_in_signed);
      end else if ((r_state == ST_CALC) && !flush_i) begin
        r_rem <= w_next_rem;
        r_quo <= w_next_quo;
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_enter_done) begin
        result_o  <= w_result;
        rd_addr_o <= (r_state == ST_IDLE) ? rd_addr_i : r_rd;
      end

      done_o <= w_enter_done;
    end
  end

endmodule
